// File: rtl/mealy_pkg.sv
// rtl/mealy_pkg.sv - state encodings and transition table of the lab 6-state Mealy encoder
// Shared by the encoder and the decoder so both always agree on the table.
package mealy_pkg;

    localparam int NUM_STATES = 6;

    typedef enum logic [2:0] {
        S0 = 3'b000,
        S1 = 3'b001,
        S2 = 3'b010,
        S3 = 3'b011,
        S4 = 3'b100,
        S5 = 3'b101
    } state_t;

    function automatic logic [2:0] mealy_next(input logic [2:0] s, input logic i);
        case (s)
            S0:      return i ? S2 : S0;
            S1:      return i ? S4 : S0;
            S2:      return i ? S1 : S5;
            S3:      return i ? S2 : S3;
            S4:      return i ? S4 : S2;
            S5:      return i ? S4 : S3;
            default: return S0;
        endcase
    endfunction

    function automatic logic mealy_out(input logic [2:0] s, input logic i);
        case (s)
            S0:      return i;
            S1:      return 1'b1;
            S2:      return ~i;
            S3:      return ~i;
            S4:      return 1'b1;
            S5:      return 1'b0;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mealy_step.sv
// rtl/mealy_step.sv - combinational (state, in) -> (next, out) lookup of the Mealy encoder
module mealy_step
    import mealy_pkg::*;
(
    input  logic [2:0] state_i,
    input  logic       in_i,
    output logic [2:0] next_o,
    output logic       out_o
);

    assign next_o = mealy_next(state_i, in_i);
    assign out_o  = mealy_out(state_i, in_i);

endmodule

// File: rtl/mealy_seq_decoder.sv
// rtl/mealy_seq_decoder.sv - survivor-path decoder recovering encoder input bits DEPTH symbols late
// Keeps one path per still-consistent encoder state; ties go to the lowest source state, then input 0.
module mealy_seq_decoder
    import mealy_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  in_bit,
    output logic                  out_valid,
    output logic                  out_bit,
    output logic                  amb,
    output logic                  err,
    output logic [NUM_STATES-1:0] alive
);

    localparam int            CW       = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [2:0] step_next [NUM_STATES][2];
    logic       step_out  [NUM_STATES][2];

    for (genvar p = 0; p < NUM_STATES; p++) begin : g_state
        for (genvar i = 0; i < 2; i++) begin : g_in
            mealy_step u_step (
                .state_i(3'(p)),
                .in_i   (1'(i)),
                .next_o (step_next[p][i]),
                .out_o  (step_out[p][i])
            );
        end
    end

    logic [NUM_STATES-1:0] alive_q, alive_d;
    logic [DEPTH-1:0]      path_q [NUM_STATES];
    logic [DEPTH-1:0]      path_d [NUM_STATES];
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_bit_q, out_bit_d;
    logic                  amb_q, amb_d;
    logic                  err_q, err_d;

    logic [NUM_STATES-1:0] cand_alive;
    logic [DEPTH-1:0]      cand_path [NUM_STATES];
    logic [CW-1:0]         cnt_inc;
    logic                  pick_bit;
    logic                  found;
    logic                  disagree;

    // Add-compare-select: first matching (p, i) in scan order claims each next state.
    always_comb begin
        cand_alive = '0;
        for (int n = 0; n < NUM_STATES; n++) begin
            cand_path[n] = '0;
        end
        for (int p = 0; p < NUM_STATES; p++) begin
            for (int i = 0; i < 2; i++) begin
                if (alive_q[p] && (step_out[p][i] == in_bit)) begin
                    for (int n = 0; n < NUM_STATES; n++) begin
                        if ((step_next[p][i] == 3'(n)) && !cand_alive[n]) begin
                            cand_alive[n] = 1'b1;
                            cand_path[n]  = {path_q[p][DEPTH-2:0], 1'(i)};
                        end
                    end
                end
            end
        end

        pick_bit = 1'b0;
        found    = 1'b0;
        disagree = 1'b0;
        for (int n = 0; n < NUM_STATES; n++) begin
            if (cand_alive[n]) begin
                if (!found) begin
                    pick_bit = cand_path[n][DEPTH-1];
                    found    = 1'b1;
                end else if (cand_path[n][DEPTH-1] != pick_bit) begin
                    disagree = 1'b1;
                end
            end
        end

        cnt_inc = (cnt_q == CNT_FULL) ? CNT_FULL : cnt_q + 1'b1;
    end

    always_comb begin
        alive_d     = alive_q;
        path_d      = path_q;
        cnt_d       = cnt_q;
        out_valid_d = 1'b0;
        out_bit_d   = out_bit_q;
        amb_d       = amb_q;
        err_d       = 1'b0;
        if (in_valid) begin
            if (cand_alive == '0) begin
                // No consistent state left: drop the symbol and reopen every state.
                err_d   = 1'b1;
                alive_d = '1;
                for (int n = 0; n < NUM_STATES; n++) begin
                    path_d[n] = '0;
                end
                cnt_d = '0;
            end else begin
                alive_d = cand_alive;
                path_d  = cand_path;
                cnt_d   = cnt_inc;
                if (cnt_inc == CNT_FULL) begin
                    out_valid_d = 1'b1;
                    out_bit_d   = pick_bit;
                    amb_d       = disagree;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alive_q     <= NUM_STATES'(1);
            for (int n = 0; n < NUM_STATES; n++) begin
                path_q[n] <= '0;
            end
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            amb_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            alive_q     <= alive_d;
            path_q      <= path_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_bit_q   <= out_bit_d;
            amb_q       <= amb_d;
            err_q       <= err_d;
        end
    end

    assign alive     = alive_q;
    assign out_valid = out_valid_q;
    assign out_bit   = out_bit_q;
    assign amb       = amb_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mealy_seq_decoder.sv
// tb/tb_mealy_seq_decoder.sv - directed vector table plus corner sequences for mealy_seq_decoder
module tb_mealy_seq_decoder;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic       out_valid;
    logic       out_bit;
    logic       amb;
    logic       err;
    logic [5:0] alive;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mealy_seq_decoder #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_bit   (in_bit),
        .out_valid(out_valid),
        .out_bit  (out_bit),
        .amb      (amb),
        .err      (err),
        .alive    (alive)
    );

    typedef struct {
        logic       r;
        logic       v;
        logic       b;
        logic [5:0] alive;
        logic       ov;
        logic       ob;
        logic       amb;
        logic       err;
    } vec_t;

    vec_t tbl[$];

    int enc_nx [6][2] = '{'{0, 2}, '{0, 4}, '{5, 1}, '{3, 2}, '{2, 4}, '{3, 4}};
    int enc_ot [6][2] = '{'{0, 1}, '{1, 1}, '{1, 0}, '{1, 0}, '{1, 1}, '{0, 0}};

    logic [5:0]       m_alive;
    logic [DEPTH-1:0] m_path [6];
    int               m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic b);
        rst      = r;
        in_valid = v;
        in_bit   = b;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        in_bit   = 1'b0;
    endtask

    task automatic add(input logic r, input logic v, input logic b, input logic [5:0] a,
                       input logic ov, input logic ob, input logic am, input logic er);
        vec_t t;
        t.r = r; t.v = v; t.b = b; t.alive = a;
        t.ov = ov; t.ob = ob; t.amb = am; t.err = er;
        tbl.push_back(t);
    endtask

    task automatic model_reset();
        m_alive = 6'b000001;
        for (int n = 0; n < 6; n++) m_path[n] = '0;
        m_cnt = 0;
    endtask

    task automatic model_sym(input logic o, output logic e_ov, output logic e_ob,
                             output logic e_amb, output logic e_err);
        logic [5:0]       na;
        logic [DEPTH-1:0] np [6];
        logic             seen;
        na = '0;
        for (int n = 0; n < 6; n++) begin
            np[n] = '0;
            for (int p = 0; p < 6; p++) begin
                for (int i = 0; i < 2; i++) begin
                    if (!na[n] && m_alive[p] && enc_nx[p][i] == n && enc_ot[p][i] == int'(o)) begin
                        na[n] = 1'b1;
                        np[n] = {m_path[p][DEPTH-2:0], 1'(i)};
                    end
                end
            end
        end
        e_ov = 1'b0; e_ob = 1'b0; e_amb = 1'b0; e_err = 1'b0;
        if (na == '0) begin
            e_err   = 1'b1;
            m_alive = 6'b111111;
            for (int n = 0; n < 6; n++) m_path[n] = '0;
            m_cnt = 0;
        end else begin
            m_alive = na;
            for (int n = 0; n < 6; n++) m_path[n] = np[n];
            if (m_cnt < DEPTH) m_cnt++;
            if (m_cnt == DEPTH) begin
                e_ov = 1'b1;
                seen = 1'b0;
                for (int n = 0; n < 6; n++) begin
                    if (na[n]) begin
                        if (!seen) begin
                            e_ob = np[n][DEPTH-1];
                            seen = 1'b1;
                        end else if (np[n][DEPTH-1] != e_ob) begin
                            e_amb = 1'b1;
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        int         pulses;
        int         ts;
        logic       x, o, e_ov, e_ob, e_amb, e_err;

        // Test 1: symbols 1,0,1,1 from S0
        add(1, 0, 0, 6'b000001, 0, 0, 0, 0);
        add(0, 1, 1, 6'b000100, 0, 0, 0, 0);
        add(0, 1, 0, 6'b000010, 0, 0, 0, 0);
        add(0, 1, 1, 6'b010001, 0, 0, 0, 0);
        add(0, 1, 1, 6'b010100, 1, 1, 0, 0);
        // Test 3: 1,0,0 -> illegal, resync, then four 0s
        add(1, 0, 0, 6'b000001, 0, 0, 0, 0);
        add(0, 1, 1, 6'b000100, 0, 0, 0, 0);
        add(0, 1, 0, 6'b000010, 0, 0, 0, 0);
        add(0, 1, 0, 6'b111111, 0, 0, 0, 1);
        add(0, 0, 0, 6'b111111, 0, 0, 0, 0);
        add(0, 1, 0, 6'b011111, 0, 0, 0, 0);
        add(0, 1, 0, 6'b000111, 0, 0, 0, 0);
        add(0, 1, 0, 6'b000011, 0, 0, 0, 0);
        add(0, 1, 0, 6'b000001, 1, 0, 0, 0);
        // Resync then 0,1,1,1: survivors disagree at emission
        add(1, 0, 0, 6'b000001, 0, 0, 0, 0);
        add(0, 1, 1, 6'b000100, 0, 0, 0, 0);
        add(0, 1, 0, 6'b000010, 0, 0, 0, 0);
        add(0, 1, 0, 6'b111111, 0, 0, 0, 1);
        add(0, 1, 0, 6'b011111, 0, 0, 0, 0);
        add(0, 1, 1, 6'b111101, 0, 0, 0, 0);
        add(0, 1, 1, 6'b111100, 0, 0, 0, 0);
        add(0, 1, 1, 6'b111100, 1, 1, 1, 0);

        foreach (tbl[k]) begin
            step(tbl[k].r, tbl[k].v, tbl[k].b);
            check($sformatf("vec%0d alive", k), 32'(alive), 32'(tbl[k].alive));
            check($sformatf("vec%0d out_valid", k), 32'(out_valid), 32'(tbl[k].ov));
            check($sformatf("vec%0d err", k), 32'(err), 32'(tbl[k].err));
            if (tbl[k].ov) begin
                check($sformatf("vec%0d out_bit", k), 32'(out_bit), 32'(tbl[k].ob));
                check($sformatf("vec%0d amb", k), 32'(amb), 32'(tbl[k].amb));
            end
        end

        // Test 2: twelve 0s stay in S0, nine pulses starting at the 4th symbol
        step(1, 0, 0);
        pulses = 0;
        for (int k = 1; k <= 12; k++) begin
            step(0, 1, 0);
            check($sformatf("zeros%0d alive", k), 32'(alive), 32'(6'b000001));
            check($sformatf("zeros%0d out_valid", k), 32'(out_valid), 32'(k >= DEPTH));
            if (out_valid) begin
                pulses++;
                check($sformatf("zeros%0d out_bit", k), 32'(out_bit), 32'(0));
                check($sformatf("zeros%0d amb", k), 32'(amb), 32'(0));
            end
        end
        check("zeros pulse count", 32'(pulses), 32'(9));

        // Test 4: 1,0,1 separated by idle cycles, then a 4th symbol
        step(1, 0, 0);
        step(0, 1, 1);
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 0);
            check("idle1 alive", 32'(alive), 32'(6'b000100));
            check("idle1 out_valid/err", 32'({out_valid, err}), 32'(0));
        end
        step(0, 1, 0);
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 0);
            check("idle2 alive", 32'(alive), 32'(6'b000010));
            check("idle2 out_valid/err", 32'({out_valid, err}), 32'(0));
        end
        step(0, 1, 1);
        check("gap 3rd alive", 32'(alive), 32'(6'b010001));
        check("gap 3rd out_valid", 32'(out_valid), 32'(0));
        step(0, 0, 0);
        step(0, 1, 1);
        check("gap 4th alive", 32'(alive), 32'(6'b010100));
        check("gap 4th out_valid", 32'(out_valid), 32'(1));
        check("gap 4th out_bit", 32'(out_bit), 32'(1));

        // Test 6: reset with in_valid high mid-stream clears the fill count
        step(1, 0, 0);
        for (int k = 0; k < 6; k++) step(0, 1, 0);
        step(1, 1, 1);
        check("rst mid alive", 32'(alive), 32'(6'b000001));
        check("rst mid out_valid", 32'(out_valid), 32'(0));
        check("rst mid err", 32'(err), 32'(0));
        for (int k = 1; k <= DEPTH; k++) begin
            step(0, 1, 0);
            check($sformatf("rst refill%0d out_valid", k), 32'(out_valid), 32'(k == DEPTH));
        end

        // Test 5: random encoder input through the reference encoder
        step(1, 0, 0);
        model_reset();
        ts = 0;
        void'($urandom(32'd20240611));
        for (int k = 0; k < 1000; k++) begin
            x  = 1'($urandom_range(1, 0));
            o  = 1'(enc_ot[ts][int'(x)]);
            ts = enc_nx[ts][int'(x)];
            step(0, 1, o);
            model_sym(o, e_ov, e_ob, e_amb, e_err);
            check($sformatf("rnd%0d err", k), 32'(err), 32'(0));
            check($sformatf("rnd%0d true state alive", k), 32'(alive[ts]), 32'(1));
            check($sformatf("rnd%0d alive", k), 32'(alive), 32'(m_alive));
            check($sformatf("rnd%0d out_valid", k), 32'(out_valid), 32'(e_ov));
            if (e_ov) begin
                check($sformatf("rnd%0d out_bit", k), 32'(out_bit), 32'(e_ob));
                check($sformatf("rnd%0d amb", k), 32'(amb), 32'(e_amb));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
